keccak_round_sequencer: RTL and testbench

Sequences the 5x5 lane state of the permutation datapath through a fixed number of rounds. Per round: a 5-step column pass (theta parity), then a 25-step lane pass in lane-number order, emitting the (i, j) coordinate and lane address for each step under a valid/ready handshake. A start/done handshake connects it to the top-level controller. The datapath and lane memory are the consumers of its outputs.

---
 rtl/keccak_round_sequencer.sv | 175 +++++++++++++++++
 tb/tb_keccak_round_sequencer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_round_sequencer.sv
// keccak_round_sequencer
//
// Steps the 5x5 lane state of the permutation datapath through NUM_ROUNDS
// rounds. Each round has three parts:
//   - a 5-step column pass (theta parity), with j=0 and lane_addr = step 0..4;
//   - a 25-step lane pass in lane-number order;
//   - a single round-end cycle.
// After the last round, done pulses for one cycle.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        begin a permutation (honoured in IDLE only)
//   abort        synchronous abort, returns to IDLE on the next cycle
//   step_ready   datapath accepts the current step
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the last round
//   phase        0 idle, 1 column pass, 2 lane pass, 3 round end
//   step_valid   i / j / lane_addr hold a step the datapath should consume
//   i, j         lane coordinates 0..4
//   lane_addr    lane number 5*((j+2) mod 5) + ((i+2) mod 5)
//   round        current round index 0..NUM_ROUNDS-1
//   round_end    one-cycle pulse in the round-end state
//   round_last   high while round == NUM_ROUNDS-1
module keccak_round_sequencer #(
  parameter int NUM_ROUNDS = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       step_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] phase,
  output logic       step_valid,
  output logic [2:0] i,
  output logic [2:0] j,
  output logic [4:0] lane_addr,
  output logic [4:0] round,
  output logic       round_end,
  output logic       round_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COL,
    S_LANE,
    S_RND_END,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
  localparam logic [4:0] LAST_COL   = 5'd4;
  localparam logic [4:0] LAST_LANE  = 5'd24;

  state_t state;
  logic   stepAccept;

  // lane_addr also serves as the step index. In the column pass it counts
  // columns 0..4, and in the lane pass it counts lanes 0..24.
  assign stepAccept = step_valid & step_ready;

  function automatic logic [2:0] inc5(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  // NOTE: every register, outputs included, is written only here, and only
  // with non-blocking assignments. Each branch therefore reads the values
  // from before this clock edge, and no output depends on combinational
  // ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      phase      <= 2'd0;
      step_valid <= 1'b0;
      i          <= 3'd0;
      j          <= 3'd0;
      lane_addr  <= 5'd0;
      round      <= 5'd0;
      round_end  <= 1'b0;
      round_last <= (NUM_ROUNDS == 1);
    end else begin
      // done and round_end are single-cycle pulses. They default low here.
      done      <= 1'b0;
      round_end <= 1'b0;

      if (abort) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        phase      <= 2'd0;
        step_valid <= 1'b0;
        i          <= 3'd0;
        j          <= 3'd0;
        lane_addr  <= 5'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_COL;
              busy       <= 1'b1;
              phase      <= 2'd1;
              step_valid <= 1'b1;
              i          <= 3'd3;
              j          <= 3'd0;
              lane_addr  <= 5'd0;
              round      <= 5'd0;
              round_last <= (NUM_ROUNDS == 1);
            end
          end

          S_COL: begin
            if (stepAccept) begin
              if (lane_addr == LAST_COL) begin
                // The lane pass starts at lane 0, which is (i,j) = (3,3).
                state     <= S_LANE;
                phase     <= 2'd2;
                i         <= 3'd3;
                j         <= 3'd3;
                lane_addr <= 5'd0;
              end else begin
                i         <= inc5(i);
                lane_addr <= lane_addr + 5'd1;
              end
            end
          end

          S_LANE: begin
            if (stepAccept) begin
              if (lane_addr == LAST_LANE) begin
                state      <= S_RND_END;
                phase      <= 2'd3;
                step_valid <= 1'b0;
                round_end  <= 1'b1;
              end else begin
                // Row order starts at column 3, so the row advances when i
                // wraps from 2 back to 3.
                i         <= inc5(i);
                j         <= (i == 3'd2) ? inc5(j) : j;
                lane_addr <= lane_addr + 5'd1;
              end
            end
          end

          S_RND_END: begin
            if (round_last) begin
              state <= S_DONE;
              phase <= 2'd0;
              done  <= 1'b1;
            end else begin
              state      <= S_COL;
              phase      <= 2'd1;
              step_valid <= 1'b1;
              i          <= 3'd3;
              j          <= 3'd0;
              lane_addr  <= 5'd0;
              round      <= round + 5'd1;
              round_last <= (round + 5'd1 == LAST_ROUND);
            end
          end

          S_DONE: begin
            // round keeps its final value until the next start.
            state <= S_IDLE;
            busy  <= 1'b0;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// tb_keccak_round_sequencer
//
// Self-checking bench for keccak_round_sequencer with NUM_ROUNDS=24.
//
// The reference model maps a position p to the expected output tuple, where
// p counts accepted steps plus the round-end and done cycles after start.
// It works as follows:
//   - round = p / 31 and c = p % 31;
//   - c 0..4 is the column pass;
//   - c 5..29 is lane (c-5), with i and j taken from mod-5 arithmetic;
//   - c 30 is the round end;
//   - p = 31*R is the done cycle.
// Outputs are sampled 1 time unit after each rising edge. Inputs for the
// next edge are driven at the same point.
module tb_keccak_round_sequencer;

  localparam int R   = 24;
  localparam int RND = 31;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       step_ready;
  logic       busy;
  logic       done;
  logic [1:0] phase;
  logic       step_valid;
  logic [2:0] i;
  logic [2:0] j;
  logic [4:0] lane_addr;
  logic [4:0] round;
  logic       round_end;
  logic       round_last;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic       busy;
    logic       stepValid;
    logic [1:0] phase;
    logic [2:0] i;
    logic [2:0] j;
    logic [4:0] addr;
    logic [4:0] round;
    logic       roundEnd;
    logic       roundLast;
    logic       done;
  } obs_t;

  keccak_round_sequencer #(.NUM_ROUNDS(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .step_ready(step_ready),
    .busy      (busy),
    .done      (done),
    .phase     (phase),
    .step_valid(step_valid),
    .i         (i),
    .j         (j),
    .lane_addr (lane_addr),
    .round     (round),
    .round_end (round_end),
    .round_last(round_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Coordinates carry no meaning when step_valid is low. Phase carries no
  // meaning in the done cycle. Both are masked so the comparisons do not
  // depend on them.
  function automatic obs_t sample();
    obs_t o;
    o.busy      = busy;
    o.stepValid = step_valid;
    o.phase     = phase;
    o.i         = i;
    o.j         = j;
    o.addr      = lane_addr;
    o.round     = round;
    o.roundEnd  = round_end;
    o.roundLast = round_last;
    o.done      = done;
    if (!o.stepValid) begin
      o.i    = 3'd0;
      o.j    = 3'd0;
      o.addr = 5'd0;
    end
    if (o.done) o.phase = 2'd0;
    return o;
  endfunction

  function automatic obs_t exp_at(input int p);
    obs_t e;
    int   r;
    int   c;
    int   k;
    e = '0;
    r = p / RND;
    c = p % RND;
    e.busy = 1'b1;
    if (r >= R) begin
      e.round     = 5'(R - 1);
      e.roundLast = 1'b1;
      e.done      = 1'b1;
    end else begin
      e.round     = 5'(r);
      e.roundLast = (r == R - 1);
      if (c < 5) begin
        e.stepValid = 1'b1;
        e.phase     = 2'd1;
        e.i         = 3'((c + 3) % 5);
        e.addr      = 5'(c);
      end else if (c < 30) begin
        k           = c - 5;
        e.stepValid = 1'b1;
        e.phase     = 2'd2;
        e.addr      = 5'(k);
        e.i         = 3'((k % 5 + 3) % 5);
        e.j         = 3'((k / 5 + 3) % 5);
      end else begin
        e.phase    = 2'd3;
        e.roundEnd = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic obs_t idle_after_run();
    obs_t e;
    e           = '0;
    e.round     = 5'(R - 1);
    e.roundLast = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    obs_t e;
    rst_n      = 1'b0;
    start      = 1'b1;
    abort      = 1'b0;
    step_ready = 1'b0;
    tick();
    tick();
    e           = '0;
    e.roundLast = (R == 1);
    o           = sample();
    checks++;
    if (o !== e) $display("FAIL reset_state got %h want %h", o, e);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    tick();
    o = sample();
    checks++;
    if (o !== e) $display("FAIL reset_idle got %h want %h", o, e);
    else passed++;
  endtask

  task automatic test_full_run();
    obs_t o;
    obs_t e;
    int   p;
    int   cyc;
    int   ends;
    int   doneCyc;
    step_ready = 1'b1;
    start      = 1'b1;
    tick();
    start   = 1'b0;
    p       = 0;
    cyc     = 0;
    ends    = 0;
    doneCyc = -1;
    while (p <= R * RND && cyc < 2000) begin
      o = sample();
      e = exp_at(p);
      checks++;
      if (o !== e) $display("FAIL full_run p=%0d got %h want %h", p, o, e);
      else passed++;
      if (o.roundEnd) ends++;
      if (o.done && doneCyc < 0) doneCyc = cyc;
      tick();
      cyc++;
      p++;
    end
    // Edges after the sampling edge. Counting the start edge itself as
    // cycle 1, done rises on cycle 745.
    checks++;
    if (doneCyc != R * RND) $display("FAIL full_run_done_cycle got %0d want %0d", doneCyc, R * RND);
    else passed++;
    checks++;
    if (ends != R) $display("FAIL full_run_round_end_count got %0d want %0d", ends, R);
    else passed++;
    o = sample();
    e = idle_after_run();
    checks++;
    if (o !== e) $display("FAIL full_run_idle got %h want %h", o, e);
    else passed++;
  endtask

  task automatic test_lane_order();
    obs_t        o;
    logic [24:0] seen;
    logic [10:0] got;
    step_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    seen = '0;
    for (int k = 0; k < 25; k++) begin
      o   = sample();
      got = {o.i, o.j, o.addr};
      if (o.addr < 5'd25) seen[o.addr] = 1'b1;
      if (k == 0) begin
        checks++;
        if (got !== {3'd3, 3'd3, 5'd0}) $display("FAIL lane_order_0 got %h want %h", got, {3'd3, 3'd3, 5'd0});
        else passed++;
      end
      if (k == 1) begin
        checks++;
        if (got !== {3'd4, 3'd3, 5'd1}) $display("FAIL lane_order_1 got %h want %h", got, {3'd4, 3'd3, 5'd1});
        else passed++;
      end
      if (k == 2) begin
        checks++;
        if (got !== {3'd0, 3'd3, 5'd2}) $display("FAIL lane_order_2 got %h want %h", got, {3'd0, 3'd3, 5'd2});
        else passed++;
      end
      if (k == 24) begin
        checks++;
        if (got !== {3'd2, 3'd2, 5'd24}) $display("FAIL lane_order_24 got %h want %h", got, {3'd2, 3'd2, 5'd24});
        else passed++;
      end
      tick();
    end
    checks++;
    if (seen !== {25{1'b1}}) $display("FAIL lane_order_unique got %h want %h", seen, {25{1'b1}});
    else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    obs_t o;
    obs_t e;
    int   p;
    int   cyc;
    int   acc;
    logic rdy;
    start      = 1'b1;
    step_ready = 1'b1;
    tick();
    start = 1'b0;
    p     = 0;
    cyc   = 0;
    acc   = 0;
    while (p <= R * RND && cyc < 5000) begin
      o = sample();
      e = exp_at(p);
      checks++;
      if (o !== e) $display("FAIL backpressure p=%0d got %h want %h", p, o, e);
      else passed++;
      rdy        = 1'($urandom_range(0, 1));
      step_ready = rdy;
      if (o.stepValid && rdy) acc++;
      tick();
      cyc++;
      if (p < R * RND && (p % RND) < 30) p += int'(rdy);
      else p++;
    end
    checks++;
    if (p <= R * RND) $display("FAIL backpressure_timeout got p=%0d want %0d", p, R * RND + 1);
    else passed++;
    checks++;
    if (acc != 30 * R) $display("FAIL backpressure_accepts got %0d want %0d", acc, 30 * R);
    else passed++;
    o = sample();
    e = idle_after_run();
    checks++;
    if (o !== e) $display("FAIL backpressure_idle got %h want %h", o, e);
    else passed++;
    step_ready = 1'b1;
  endtask

  task automatic test_abort();
    obs_t       o;
    obs_t       e;
    int         p;
    int         target;
    logic [5:0] ctl;
    logic       bad;
    target     = 5 * RND + 5 + 12;
    step_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    p     = 0;
    while (p < target) begin
      tick();
      p++;
    end
    o = sample();
    e = exp_at(target);
    checks++;
    if (o !== e) $display("FAIL abort_position got %h want %h", o, e);
    else passed++;
    // abort and start together: abort wins.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    o     = sample();
    ctl   = {o.busy, o.stepValid, o.phase, o.roundEnd, o.done};
    checks++;
    if (ctl !== 6'd0) $display("FAIL abort_idle got %b want %b", ctl, 6'd0);
    else passed++;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy || round_end) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) $display("FAIL abort_no_done got %b want %b", bad, 1'b0);
    else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    o     = sample();
    e     = exp_at(0);
    checks++;
    if (o !== e) $display("FAIL abort_restart got %h want %h", o, e);
    else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored();
    obs_t o;
    obs_t e;
    int   p;
    int   doneCyc;
    step_ready = 1'b1;
    start      = 1'b1;
    tick();
    start   = 1'b0;
    p       = 0;
    doneCyc = -1;
    while (p <= R * RND) begin
      o = sample();
      e = exp_at(p);
      checks++;
      if (o !== e) $display("FAIL start_ignored p=%0d got %h want %h", p, o, e);
      else passed++;
      if (o.done && doneCyc < 0) doneCyc = p;
      start = (p >= 2 * RND && p < 2 * RND + 5);
      tick();
      p++;
    end
    start = 1'b0;
    checks++;
    if (doneCyc != R * RND) $display("FAIL start_ignored_done_cycle got %0d want %0d", doneCyc, R * RND);
    else passed++;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    obs_t e;
    step_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (3 * RND + 5 + 7) tick();
    o = sample();
    e = exp_at(3 * RND + 5 + 7);
    checks++;
    if (o !== e) $display("FAIL reset_mid_position got %h want %h", o, e);
    else passed++;
    // Reset is asserted between edges and must act without a clock edge.
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    e           = '0;
    e.roundLast = (R == 1);
    o           = sample();
    checks++;
    if (o !== e) $display("FAIL reset_mid_immediate got %h want %h", o, e);
    else passed++;
    tick();
    tick();
    o = sample();
    checks++;
    if (o !== e) $display("FAIL reset_mid_start_ignored got %h want %h", o, e);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    o = sample();
    checks++;
    if (o !== e) $display("FAIL reset_mid_release got %h want %h", o, e);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_lane_order();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
